loop_buffer_fsm: RTL and testbench
==================================

Name: loop_buffer_fsm

Overview:
- Parametrised successor of the single-loop detector/buffer in the fetch path.
- Detects a backward conditional branch whose loop body fits in DEPTH entries.
- Captures the body on the next pass, then replays it from local storage while asserting block_signal to freeze fetch.
- Exits on mispredict with a flush and a redirect PC; adds a configurable depth, an arm timeout, an iteration counter and replay-PC output.

Parameters:
XLEN, 32, instruction/PC/immediate width
DEPTH, 8, max loop body entries (branch included); power of two, >=2
ARM_TIMEOUT, 8, max consecutive non-capturing cycles tolerated in ARM/FILL
CNT_W, 16, iteration counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
curr_PC  in  XLEN  PC of instruction presented this cycle
instruction  in  XLEN  instruction presented this cycle
immediate  in  XLEN  sign-extended branch immediate
bubble_idex  in  1  pipeline stall; replay index holds, capture suppressed
mispredict  in  1  branch resolved mispredicted (loop exit)
block_signal  out  1  fetch frozen; instructions come from buffer
flush  out  1  one-cycle flush pulse on loop exit
new_pc  out  XLEN  redirect PC, valid with flush
out_instruction  out  XLEN  instruction to decode
replay_pc  out  XLEN  PC of out_instruction during REPLAY, else curr_PC
iter_count  out  CNT_W  completed replay iterations of current loop, saturating

Behaviour:
- Reset (async, active-high): state IDLE; block_signal=0, flush=0, new_pc=0, iter_count=0; all indices 0; buffer contents don't-care.
- States: IDLE, ARM, FILL, REPLAY.
- Candidate: instruction[6:0]==7'b1100011, immediate negative, immediate[1:0]==0, N=(-immediate>>2)+1<=DEPTH, bubble_idex=0.
  - Latch branch_pc=curr_PC, target=curr_PC+immediate, N.
  - Non-candidates, including imm=0 and oversize bodies, are ignored.
- IDLE: candidate -> ARM.
- ARM: curr_PC==target and no bubble -> write entry 0, fill_idx=1, -> FILL. Otherwise increment timeout counter; reaching ARM_TIMEOUT -> IDLE.
- FILL: curr_PC==target+4*fill_idx and no bubble -> write entry fill_idx, increment, clear timeout.
  - Last entry (PC==branch_pc) written -> REPLAY next cycle, rd_idx=0.
  - Other cycles count timeout; ARM_TIMEOUT -> IDLE.
- REPLAY:
  - block_signal=1.
  - out_instruction=buf[rd_idx] (combinational read); replay_pc=target+4*rd_idx.
  - rd_idx advances each cycle without bubble_idex; wraps N-1 -> 0.
  - Each wrap increments iter_count, saturating at all-ones.
- Non-REPLAY: out_instruction=instruction (combinational pass-through), block_signal=0.
- mispredict in REPLAY:
  - flush=1 and new_pc=branch_pc+4 registered for exactly one cycle.
  - block_signal=0 from next cycle; -> IDLE.
  - iter_count holds its value until the next ARM entry, which clears it.
- mispredict in ARM/FILL: -> IDLE, no flush.
- mispredict and candidate in the same cycle: mispredict wins; candidate dropped.
- Candidates seen during ARM/FILL/REPLAY are ignored.
- bubble_idex during REPLAY with mispredict: flush still fires.

Optional Feature:
LOOP_BUF_REUSE_EN
- Defined: on exit, tag {branch_pc, N, valid} is kept. A later candidate matching the tag enters ARM flagged reuse. In ARM, curr_PC==target goes straight to REPLAY with rd_idx=0 outputting entry 0 that cycle; FILL is skipped.
- A new non-matching fill overwrites the tag. Reset clears it.
- Undefined: every detection re-fills. No tag logic.

Decomposition:
- loop_buf_pkg:
  - state enum
  - BRANCH_OPCODE constant
  - index width localparam, $clog2(DEPTH)
- Sub-module loop_buf_store: DEPTH x XLEN register array, one synchronous write port, one combinational read port.

Test Plan:
1. Body 0x100-0x10C (0x13, 0x14, 0x15, 0xFC000AE3 with imm=-12), 4 filler cycles, second pass -> block_signal=1 the cycle after 0x10C is captured; out_instruction repeats 0x13, 0x14, 0x15, 0xFC000AE3; replay_pc 0x100..0x10C.
2. mispredict in REPLAY -> flush=1 for one cycle with new_pc=0x110; block_signal=0 next cycle; iter_count equals completed wraps.
3. bubble_idex high 2 cycles mid-REPLAY -> out_instruction and replay_pc hold; sequence resumes without skip.
4. Branch with imm=-40 at DEPTH=8 (N=11) -> no state change, block_signal stays 0; imm=-6 -> ignored.
5. Detect, then curr_PC never reaches target for 8 cycles -> IDLE. Separately, assert reset mid-REPLAY -> block_signal=0 without waiting for a clock edge.
6. Same loop re-encountered -> with LOOP_BUF_REUSE_EN, replay starts when curr_PC=0x100 (no fill pass); without it, a full fill pass precedes replay.

Source files
------------

// File: rtl/loop_buf_pkg.sv
// Shared types and constants for the fetch-path loop buffer.
// Optional tag-based body reuse is enabled by defining LOOP_BUF_REUSE_EN.
package loop_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FILL,
        ST_REPLAY
    } lb_state_e;

    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_DEPTH);

    // Index width for a body buffer of the given (power-of-two) depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/loop_buffer_fsm_if.sv
// Fetch-side bundle between the front end (master) and the loop buffer (slave).
interface loop_buffer_fsm_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  curr_PC;
    logic [XLEN-1:0]  instruction;
    logic [XLEN-1:0]  immediate;
    logic             bubble_idex;
    logic             mispredict;
    logic             block_signal;
    logic             flush;
    logic [XLEN-1:0]  new_pc;
    logic [XLEN-1:0]  out_instruction;
    logic [XLEN-1:0]  replay_pc;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output curr_PC, instruction, immediate, bubble_idex, mispredict,
        input  block_signal, flush, new_pc, out_instruction, replay_pc, iter_count
    );

    modport slave (
        input  curr_PC, instruction, immediate, bubble_idex, mispredict,
        output block_signal, flush, new_pc, out_instruction, replay_pc, iter_count
    );
endinterface

// File: rtl/loop_buf_store.sv
// Loop body storage: DEPTH x XLEN registers, one synchronous write port and
// one combinational read port.
module loop_buf_store
    import loop_buf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata
);
    logic [XLEN-1:0] mem [DEPTH];

    // NOTE: the array has no reset; every entry is written by a fill before
    // replay can read it, so clearing it would only cost a reset tree.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/loop_buffer_fsm.sv
// Loop detector/buffer: captures a short backward-branch loop body and replays
// it while freezing fetch. Define LOOP_BUF_REUSE_EN to reuse a held body.
module loop_buffer_fsm
    import loop_buf_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 8,
    parameter int ARM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input logic             clk,
    input logic             reset,
    loop_buffer_fsm_if.slave bus
);
    localparam int IDX_W = idx_width(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);

    lb_state_e        state_q, state_d;
    logic [XLEN-1:0]  branch_pc_q, branch_pc_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  new_pc_q, new_pc_d;

    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [XLEN-1:0]  rdata;

`ifdef LOOP_BUF_REUSE_EN
    logic             tag_valid_q, tag_valid_d;
    logic [XLEN-1:0]  tag_pc_q, tag_pc_d;
    logic [LEN_W-1:0] tag_len_q, tag_len_d;
    logic             reuse_q, reuse_d;
`endif

    // Candidate decode: body length N = (-imm >> 2) + 1 must fit the buffer.
    logic [XLEN-1:0]  neg_imm;
    logic [XLEN-1:0]  body_words;
    logic [LEN_W-1:0] cand_len;
    logic             cand;
    logic [XLEN-1:0]  fill_pc;
    logic             at_target;
    logic             at_fill_pc;
    logic             tmo_expired;

    assign neg_imm     = -bus.immediate;
    assign body_words  = (neg_imm >> 2) + XLEN'(1);
    assign cand_len    = body_words[LEN_W-1:0];
    assign cand        = (bus.instruction[6:0] == BRANCH_OPCODE)
                       && bus.immediate[XLEN-1]
                       && (bus.immediate[1:0] == 2'b00)
                       && (body_words <= XLEN'(DEPTH))
                       && !bus.bubble_idex;
    assign fill_pc     = target_q + (XLEN'(fill_idx_q) << 2);
    assign at_target   = (bus.curr_PC == target_q) && !bus.bubble_idex;
    assign at_fill_pc  = (bus.curr_PC == fill_pc) && !bus.bubble_idex;
    assign tmo_expired = (tmo_q == TMO_W'(ARM_TIMEOUT - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch
        // can leave a value unassigned and infer a latch.
        state_d     = state_q;
        branch_pc_d = branch_pc_q;
        target_d    = target_q;
        len_d       = len_q;
        fill_idx_d  = fill_idx_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = tmo_q;
        iter_d      = iter_q;
        flush_d     = 1'b0;
        new_pc_d    = new_pc_q;
        we          = 1'b0;
        waddr       = fill_idx_q;
`ifdef LOOP_BUF_REUSE_EN
        tag_valid_d = tag_valid_q;
        tag_pc_d    = tag_pc_q;
        tag_len_d   = tag_len_q;
        reuse_d     = reuse_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (cand && !bus.mispredict) begin
                    state_d     = ST_ARM;
                    branch_pc_d = bus.curr_PC;
                    target_d    = bus.curr_PC + bus.immediate;
                    len_d       = cand_len;
                    tmo_d       = '0;
                    iter_d      = '0;
`ifdef LOOP_BUF_REUSE_EN
                    reuse_d     = tag_valid_q && (tag_pc_q == bus.curr_PC)
                                && (tag_len_q == cand_len);
`endif
                end
            end

            ST_ARM: begin
                if (bus.mispredict) begin
                    state_d = ST_IDLE;
                end else if (at_target) begin
                    state_d    = ST_FILL;
                    we         = 1'b1;
                    waddr      = '0;
                    fill_idx_d = IDX_W'(1);
                    tmo_d      = '0;
`ifdef LOOP_BUF_REUSE_EN
                    // A held body for this very loop skips the fill pass.
                    if (reuse_q) begin
                        state_d  = ST_REPLAY;
                        we       = 1'b0;
                        rd_idx_d = '0;
                    end else begin
                        tag_valid_d = 1'b0;
                    end
`endif
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_FILL: begin
                if (bus.mispredict) begin
                    state_d = ST_IDLE;
                end else if (at_fill_pc) begin
                    we    = 1'b1;
                    tmo_d = '0;
                    if (LEN_W'(fill_idx_q) == len_q - LEN_W'(1)) begin
                        state_d  = ST_REPLAY;
                        rd_idx_d = '0;
`ifdef LOOP_BUF_REUSE_EN
                        tag_valid_d = 1'b1;
                        tag_pc_d    = branch_pc_q;
                        tag_len_d   = len_q;
`endif
                    end else begin
                        fill_idx_d = fill_idx_q + IDX_W'(1);
                    end
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_REPLAY: begin
                if (bus.mispredict) begin
                    state_d  = ST_IDLE;
                    flush_d  = 1'b1;
                    new_pc_d = branch_pc_q + XLEN'(4);
                end else if (!bus.bubble_idex) begin
                    if (LEN_W'(rd_idx_q) == len_q - LEN_W'(1)) begin
                        rd_idx_d = '0;
                        if (iter_q != {CNT_W{1'b1}}) begin
                            iter_d = iter_q + CNT_W'(1);
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            branch_pc_q <= '0;
            target_q    <= '0;
            len_q       <= '0;
            fill_idx_q  <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            iter_q      <= '0;
            flush_q     <= 1'b0;
            new_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            branch_pc_q <= branch_pc_d;
            target_q    <= target_d;
            len_q       <= len_d;
            fill_idx_q  <= fill_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            iter_q      <= iter_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
        end
    end

`ifdef LOOP_BUF_REUSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid_q <= 1'b0;
            tag_pc_q    <= '0;
            tag_len_q   <= '0;
            reuse_q     <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_pc_q    <= tag_pc_d;
            tag_len_q   <= tag_len_d;
            reuse_q     <= reuse_d;
        end
    end
`endif

    loop_buf_store #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.instruction),
        .raddr (rd_idx_q),
        .rdata (rdata)
    );

    assign bus.block_signal    = (state_q == ST_REPLAY);
    assign bus.out_instruction = bus.block_signal ? rdata : bus.instruction;
    assign bus.replay_pc       = bus.block_signal ? target_q + (XLEN'(rd_idx_q) << 2)
                                                  : bus.curr_PC;
    assign bus.flush           = flush_q;
    assign bus.new_pc          = new_pc_q;
    assign bus.iter_count      = iter_q;

endmodule

// File: tb/tb_loop_buffer_fsm.sv
// Scoreboard bench for loop_buffer_fsm: directed loop scenarios plus random
// loops, checked against a behavioural model of the loop buffer.
module tb_loop_buffer_fsm;
    localparam int XLEN        = 32;
    localparam int DEPTH       = 8;
    localparam int ARM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    localparam int M_IDLE   = 0;
    localparam int M_ARM    = 1;
    localparam int M_FILL   = 2;
    localparam int M_REPLAY = 3;

    typedef struct {
        logic             block;
        logic [XLEN-1:0]  ins;
        logic [XLEN-1:0]  rpc;
        logic             flush;
        logic [XLEN-1:0]  npc;
        logic [CNT_W-1:0] iter;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    loop_buffer_fsm_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    loop_buffer_fsm #(
        .XLEN        (XLEN),
        .DEPTH       (DEPTH),
        .ARM_TIMEOUT (ARM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];

    // Behavioural model: what the loop buffer holds and how far replay got.
    int               m_mode;
    logic [XLEN-1:0]  m_bpc, m_tgt, m_npc, m_tag_pc;
    int               m_n, m_got, m_wait, m_adv, m_tag_n;
    logic [CNT_W-1:0] m_iter;
    logic             m_flush, m_reuse, m_tag_ok;
    logic [XLEN-1:0]  m_body [DEPTH];

    // Current program under test.
    logic [XLEN-1:0]  prog [DEPTH+2];
    int               prog_n;
    logic [XLEN-1:0]  prog_base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic bit is_candidate(input logic [XLEN-1:0] ins, input logic [XLEN-1:0] imm,
                                        input logic bub);
        longint s;
        s = longint'($signed(imm));
        if (bub || ins[6:0] != 7'b1100011 || s >= 0 || (s % 4) != 0) return 1'b0;
        return ((-s) / 4 + 1) <= DEPTH;
    endfunction

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_iter   = '0;
        m_flush  = 1'b0;
        m_npc    = '0;
        m_tag_ok = 1'b0;
        m_reuse  = 1'b0;
        m_n      = 1;
        m_adv    = 0;
    endfunction

    function automatic exp_t model_out(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins);
        exp_t e;
        int   pos;
        pos     = m_adv % m_n;
        e.block = (m_mode == M_REPLAY);
        e.ins   = e.block ? m_body[pos] : ins;
        e.rpc   = e.block ? m_tgt + 32'(4 * pos) : pc;
        e.flush = m_flush;
        e.npc   = m_npc;
        e.iter  = m_iter;
        e.cyc   = cyc;
        return e;
    endfunction

    function automatic void model_step(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                                       input logic [XLEN-1:0] imm, input logic bub,
                                       input logic mis);
        bit reuse_hit;
        m_flush   = 1'b0;
        reuse_hit = 1'b0;
        case (m_mode)
            M_IDLE: if (!mis && is_candidate(ins, imm, bub)) begin
                m_mode  = M_ARM;
                m_bpc   = pc;
                m_tgt   = pc + imm;
                m_n     = int'((-longint'($signed(imm))) / 4) + 1;
                m_wait  = 0;
                m_iter  = '0;
                m_reuse = m_tag_ok && (m_tag_pc == pc) && (m_tag_n == m_n);
            end
            M_ARM, M_FILL: begin
                logic [XLEN-1:0] want_pc;
                want_pc = (m_mode == M_ARM) ? m_tgt : m_tgt + 32'(4 * m_got);
`ifdef LOOP_BUF_REUSE_EN
                reuse_hit = (m_mode == M_ARM) && m_reuse;
`endif
                if (mis) begin
                    m_mode = M_IDLE;
                end else if (pc == want_pc && !bub) begin
                    m_wait = 0;
                    if (reuse_hit) begin
                        m_mode = M_REPLAY;
                        m_adv  = 0;
                    end else begin
                        if (m_mode == M_ARM) begin
                            m_got    = 0;
                            m_tag_ok = 1'b0;
                            m_mode   = M_FILL;
                        end
                        m_body[m_got] = ins;
                        m_got++;
                        if (m_got == m_n) begin
                            m_mode   = M_REPLAY;
                            m_adv    = 0;
                            m_tag_ok = 1'b1;
                            m_tag_pc = m_bpc;
                            m_tag_n  = m_n;
                        end
                    end
                end else begin
                    m_wait++;
                    if (m_wait >= ARM_TIMEOUT) m_mode = M_IDLE;
                end
            end
            M_REPLAY: if (mis) begin
                m_flush = 1'b1;
                m_npc   = m_bpc + 32'd4;
                m_mode  = M_IDLE;
            end else if (!bub) begin
                m_adv++;
                m_iter = (m_adv / m_n > 65535) ? 16'hFFFF : 16'(m_adv / m_n);
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // Called at posedge+1: present inputs for one cycle, log the expected outputs.
    task automatic drive(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                         input logic [XLEN-1:0] imm, input logic bub, input logic mis);
        bus.curr_PC     = pc;
        bus.instruction = ins;
        bus.immediate   = imm;
        bus.bubble_idex = bub;
        bus.mispredict  = mis;
        sb.push_back(model_out(pc, ins));
        model_step(pc, ins, imm, bub, mis);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Fetch traffic while the buffer is replaying: random PCs, often branches.
    task automatic junk(input logic bub, input logic mis);
        logic [31:0] r;
        r = $urandom();
        drive(32'h0005_0000 + 32'(4 * $urandom_range(0, 255)),
              {r[31:7], (r[0] ? 7'b1100011 : 7'b0010011)},
              -32'(4 * $urandom_range(1, 6)), bub, mis);
    endtask

    task automatic filler(input int k);
        for (int i = 0; i < k; i++) drive(32'h0004_0000 + 32'(4 * i), 32'h0000_0013, '0, 1'b0, 1'b0);
    endtask

    task automatic pass(input int bub_pct);
        logic [XLEN-1:0] imm;
        imm = -32'(4 * (prog_n - 1));
        for (int i = 0; i < prog_n; i++) begin
            if ($urandom_range(0, 99) < bub_pct)
                drive(prog_base + 32'(4 * i), prog[i], imm, 1'b1, 1'b0);
            drive(prog_base + 32'(4 * i), prog[i], imm, 1'b0, 1'b0);
        end
    endtask

    task automatic replay_cycles(input int k, input int bub_pct);
        for (int i = 0; i < k; i++) junk($urandom_range(0, 99) < bub_pct, 1'b0);
    endtask

    task automatic exit_loop();
        if (m_mode == M_REPLAY && (m_adv % m_n) == m_n - 1) junk(1'b0, 1'b0);
        junk($urandom_range(0, 3) == 0, 1'b1);
        junk(1'b0, 1'b0);
        junk(1'b0, 1'b0);
    endtask

    task automatic settle();
        if (m_mode == M_REPLAY) exit_loop();
        filler(ARM_TIMEOUT);
    endtask

    task automatic load_random_prog(input logic [XLEN-1:0] base, input int n);
        logic [31:0] r;
        prog_base = base;
        prog_n    = n;
        for (int i = 0; i < n - 1; i++) begin
            r       = $urandom();
            prog[i] = {r[31:7], 7'b0010011};
        end
        r           = $urandom();
        prog[n - 1] = {r[31:7], 7'b1100011};
    endtask

    // Called at posedge+1 with the DUT mid-replay.
    task automatic reset_pulse();
        #6;
        check("block_before_reset", 64'(bus.block_signal), 64'(m_mode == M_REPLAY));
        reset = 1'b1;
        #1;
        check("block_async_reset", 64'(bus.block_signal), 64'd0);
        check("flush_async_reset", 64'(bus.flush), 64'd0);
        check("iter_async_reset", 64'(bus.iter_count), 64'd0);
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("block_signal@%0d", e.cyc), 64'(bus.block_signal), 64'(e.block));
            check($sformatf("out_instruction@%0d", e.cyc), 64'(bus.out_instruction), 64'(e.ins));
            check($sformatf("replay_pc@%0d", e.cyc), 64'(bus.replay_pc), 64'(e.rpc));
            check($sformatf("flush@%0d", e.cyc), 64'(bus.flush), 64'(e.flush));
            check($sformatf("iter_count@%0d", e.cyc), 64'(bus.iter_count), 64'(e.iter));
            if (e.flush) check($sformatf("new_pc@%0d", e.cyc), 64'(bus.new_pc), 64'(e.npc));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.curr_PC     = '0;
        bus.instruction = '0;
        bus.immediate   = '0;
        bus.bubble_idex = 1'b0;
        bus.mispredict  = 1'b0;
        model_reset();
        #1;
        check("reset_block", 64'(bus.block_signal), 64'd0);
        check("reset_flush", 64'(bus.flush), 64'd0);
        check("reset_new_pc", 64'(bus.new_pc), 64'd0);
        check("reset_iter", 64'(bus.iter_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Loop 0x100..0x10C, branch imm=-12: detect, fill, replay, exit.
        prog_base = 32'h100;
        prog_n    = 4;
        prog[0]   = 32'h0000_0013;
        prog[1]   = 32'h0000_0014;
        prog[2]   = 32'h0000_0015;
        prog[3]   = 32'hFC00_0AE3;
        pass(0);
        filler(4);
        pass(0);
        replay_cycles(10, 0);
        exit_loop();

        // Same loop again, with a two-cycle bubble in the middle of replay.
        pass(0);
        filler(2);
        pass(0);
        replay_cycles(3, 0);
        junk(1'b1, 1'b0);
        junk(1'b1, 1'b0);
        replay_cycles(6, 0);
        exit_loop();
        settle();

        // Oversize body, misaligned and zero immediates are all ignored.
        drive(32'h328, 32'hFC00_0AE3, -32'd40, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(32'h300 + 32'(4 * i), 32'h13, '0, 1'b0, 1'b0);
        drive(32'h40C, 32'hFC00_0AE3, -32'd6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(32'h406 + 32'(4 * i), 32'h13, '0, 1'b0, 1'b0);
        drive(32'h50C, 32'h0000_0063, '0, 1'b0, 1'b0);
        drive(32'h50C, 32'h0000_0013, '0, 1'b0, 1'b0);

        // Candidate with a simultaneous mispredict is dropped.
        drive(32'h10C, 32'hFC00_0AE3, -32'd12, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(32'h100 + 32'(4 * i), prog[i], '0, 1'b0, 1'b0);
        settle();

        // Arm timeout, then mispredict during fill.
        drive(32'h10C, 32'hFC00_0AE3, -32'd12, 1'b0, 1'b0);
        filler(ARM_TIMEOUT);
        for (int i = 0; i < 3; i++) drive(32'h100 + 32'(4 * i), prog[i], '0, 1'b0, 1'b0);
        drive(32'h10C, 32'hFC00_0AE3, -32'd12, 1'b0, 1'b0);
        drive(32'h100, prog[0], '0, 1'b0, 1'b0);
        drive(32'h104, prog[1], '0, 1'b0, 1'b0);
        drive(32'h108, prog[2], '0, 1'b1, 1'b1);
        settle();

        // Reset asserted in the middle of replay.
        pass(0);
        pass(0);
        replay_cycles(5, 0);
        reset_pulse();

        // Random loops, some oversize, some timing out, some re-encountered.
        for (int t = 0; t < 40; t++) begin
            if (t == 0 || $urandom_range(0, 2) != 0)
                load_random_prog(32'h1000 + 32'($urandom_range(0, 15) * 32'h100),
                                 $urandom_range(2, DEPTH + 1));
            pass(0);
            filler($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) begin
                drive(prog_base, prog[0], '0, 1'b0, 1'b0);
                drive(prog_base + 32'd4, prog[1], '0, 1'b0, 1'b1);
            end else begin
                pass(15);
            end
            replay_cycles($urandom_range(0, 25), 20);
            exit_loop();
            settle();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
